// File: rtl/seven_segment_monitor.sv
// -----------------------------------------------------------------------------
// seven_segment_monitor
// Receive-side checker for a 7-segment digit display. Synchronizes and
// deglitches the segment bus, decodes stable patterns to BCD, checks the 0..9
// wrap sequence and measures the interval between accepted digits.
//
// Optional feature macro: SEGMON_PERIOD_CHECK_EN (period tolerance check).
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   segments_in      [6:0] segment bus (bit6..bit0 = segments 7..1), async
//   clear            sync clear: FSM to IDLE, err_count=0, period_valid=0
//   expected_period  [CNT_W-1:0] nominal cycles per digit (macro only)
//   digit_out        [3:0] last accepted decoded digit
//   digit_valid      digit_out holds a legal digit
//   new_digit        pulse on each accepted legal digit
//   invalid_pattern  pulse on an accepted non-digit, non-blank pattern
//   period_out       [CNT_W-1:0] cycles between the last two accepted digits
//   period_valid     period_out is meaningful
//   seq_err          pulse: digit is not the successor of the previous one
//   err_count        [ERR_W-1:0] saturating count of seq_err + invalid_pattern
//   timing_err       pulse: period outside tolerance (macro only, else 0)
// -----------------------------------------------------------------------------
module seven_segment_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned ERR_W         = 8,
  parameter int unsigned TOL           = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       segments_in,
  input  logic             clear,
  input  logic [CNT_W-1:0] expected_period,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             new_digit,
  output logic             invalid_pattern,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count,
  output logic             timing_err
);

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned DIFF_W = CNT_W + 1;

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
  localparam logic [SEG_W-1:0]  BLANK    = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SEG_W-1:0]  sync1_q, sync2_q, cand_q, acc_q;
  logic [STAB_W-1:0] stab_q;
  logic [CNT_W-1:0]  ivl_q;

  logic              accept_c;
  logic [CNT_W-1:0]  ivl_inc_c;
  logic [4:0]        dec_c;
  logic              dec_legal_c;
  logic [3:0]        dec_digit_c;
  logic [3:0]        succ_c;
  logic [ERR_W-1:0]  err_inc_c;
  logic              timing_c;

  logic [3:0]        digit_d;
  logic              digit_valid_d, new_digit_d, invalid_d;
  logic [CNT_W-1:0]  period_d;
  logic              period_valid_d, seq_err_d, timing_d;
  logic [ERR_W-1:0]  err_d;

  // Pattern decode: {legal, digit}; blank and unknown patterns are not legal.
  function automatic logic [4:0] decode(input logic [SEG_W-1:0] seg);
    case (seg)
      7'h3F:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5B:   decode = {1'b1, 4'd2};
      7'h4F:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6D:   decode = {1'b1, 4'd5};
      7'h7C:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h67:   decode = {1'b1, 4'd9};
      default: decode = 5'b0_0000;
    endcase
  endfunction

  assign dec_c       = decode(cand_q);
  assign dec_legal_c = dec_c[4];
  assign dec_digit_c = dec_c[3:0];

  // A candidate that has held for STABLE_CYCLES synced samples and differs
  // from the accepted pattern is accepted this cycle.
  assign accept_c = (sync2_q == cand_q) && (stab_q == STAB_MAX) && (cand_q != acc_q);

  // Interval as seen at this edge: counter value it would advance to, so two
  // accepts N cycles apart report N.
  assign ivl_inc_c = (ivl_q == CNT_MAX) ? ivl_q : ivl_q + CNT_W'(1);
  assign succ_c    = (digit_out == 4'd9) ? 4'd0 : digit_out + 4'd1;
  assign err_inc_c = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);

`ifdef SEGMON_PERIOD_CHECK_EN
  // |interval - expected| in one extra bit so the subtraction cannot wrap.
  logic [DIFF_W-1:0] diff_c;
  assign diff_c   = (ivl_inc_c >= expected_period)
                  ? ({1'b0, ivl_inc_c} - {1'b0, expected_period})
                  : ({1'b0, expected_period} - {1'b0, ivl_inc_c});
  assign timing_c = (diff_c > DIFF_W'(TOL));
`else
  logic unused_expected_period;
  assign unused_expected_period = ^expected_period;
  assign timing_c = 1'b0;
`endif

  // Synchronizer, deglitch filter and interval counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      acc_q   <= '0;
      ivl_q   <= '0;
    end else begin
      sync1_q <= segments_in;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        stab_q <= '0;
      end else if (stab_q != STAB_MAX) begin
        stab_q <= stab_q + STAB_W'(1);
      end
      if (accept_c) begin
        acc_q <= cand_q;
      end
      ivl_q <= accept_c ? '0 : ivl_inc_c;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      digit_out       <= '0;
      digit_valid     <= 1'b0;
      new_digit       <= 1'b0;
      invalid_pattern <= 1'b0;
      period_out      <= '0;
      period_valid    <= 1'b0;
      seq_err         <= 1'b0;
      err_count       <= '0;
      timing_err      <= 1'b0;
    end else begin
      state_q         <= state_d;
      digit_out       <= digit_d;
      digit_valid     <= digit_valid_d;
      new_digit       <= new_digit_d;
      invalid_pattern <= invalid_d;
      period_out      <= period_d;
      period_valid    <= period_valid_d;
      seq_err         <= seq_err_d;
      err_count       <= err_d;
      timing_err      <= timing_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d        = state_q;
    digit_d        = digit_out;
    digit_valid_d  = digit_valid;
    new_digit_d    = 1'b0;
    invalid_d      = 1'b0;
    period_d       = period_out;
    period_valid_d = period_valid;
    seq_err_d      = 1'b0;
    err_d          = err_count;
    timing_d       = 1'b0;

    if (clear) begin
      // A same-cycle accept still updates the shown digit but raises nothing.
      state_d        = IDLE;
      err_d          = '0;
      period_valid_d = 1'b0;
      if (accept_c) begin
        digit_valid_d = dec_legal_c;
        if (dec_legal_c) begin
          digit_d = dec_digit_c;
        end
      end
    end else if (accept_c) begin
      if (cand_q == BLANK) begin
        digit_valid_d = 1'b0;
        state_d       = IDLE;
      end else if (!dec_legal_c) begin
        invalid_d     = 1'b1;
        digit_valid_d = 1'b0;
        err_d         = err_inc_c;
        state_d       = IDLE;
      end else begin
        new_digit_d   = 1'b1;
        digit_d       = dec_digit_c;
        digit_valid_d = 1'b1;
        case (state_q)
          IDLE: begin
            state_d        = FIRST;
            period_valid_d = 1'b0;
          end
          FIRST, TRACK: begin
            state_d        = TRACK;
            period_d       = ivl_inc_c;
            period_valid_d = 1'b1;
            timing_d       = timing_c;
            if (dec_digit_c != succ_c) begin
              seq_err_d = 1'b1;
              err_d     = err_inc_c;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_monitor.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_monitor
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a run-length
// based reference model of the monitor.
// -----------------------------------------------------------------------------
module tb_seven_segment_monitor;

  localparam int S      = 4;
  localparam int CNT_W  = 24;
  localparam int ERR_W  = 8;
  localparam int TOL    = 2;
  localparam int RL_CAP = S + 2;
  localparam int EXP_P  = 100;

`ifdef SEGMON_PERIOD_CHECK_EN
  localparam bit TE_ON = 1'b1;
`else
  localparam bit TE_ON = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic [6:0]       segments_in;
  logic             clear;
  logic [CNT_W-1:0] expected_period;
  logic [3:0]       digit_out;
  logic             digit_valid;
  logic             new_digit;
  logic             invalid_pattern;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             seq_err;
  logic [ERR_W-1:0] err_count;
  logic             timing_err;

  seven_segment_monitor #(
    .STABLE_CYCLES(S), .CNT_W(CNT_W), .ERR_W(ERR_W), .TOL(TOL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .segments_in(segments_in), .clear(clear),
    .expected_period(expected_period), .digit_out(digit_out),
    .digit_valid(digit_valid), .new_digit(new_digit),
    .invalid_pattern(invalid_pattern), .period_out(period_out),
    .period_valid(period_valid), .seq_err(seq_err), .err_count(err_count),
    .timing_err(timing_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] pat [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int seg_to_digit(input logic [6:0] v);
    for (int i = 0; i < 10; i++) if (pat[i] == v) return i;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  // A pattern is accepted when the sample stream (delayed two cycles by the
  // synchronizer) has just completed a run of exactly S+1 equal samples and
  // that value differs from the last accepted pattern.
  logic [6:0]       m_last_s;
  int               m_rl_last;
  logic [6:0]       q_v [$];
  int               q_rl [$];
  logic [6:0]       m_acc;
  int               m_n, m_last_acc, m_run;
  logic [3:0]       m_digit;
  logic             m_valid, m_nd, m_inv, m_seq, m_te, m_pv;
  logic [CNT_W-1:0] m_period;
  logic [ERR_W-1:0] m_err;

  task automatic model_reset();
    m_last_s = '0; m_rl_last = RL_CAP;
    q_v = '{7'h00, 7'h00}; q_rl = '{RL_CAP, RL_CAP};
    m_acc = '0; m_n = 0; m_last_acc = -1; m_run = 0;
    m_digit = '0; m_valid = 0; m_nd = 0; m_inv = 0; m_seq = 0; m_te = 0;
    m_pv = 0; m_period = '0; m_err = '0;
  endtask

  task automatic model_step();
    int cur_rl, r, d, per, dev;
    logic [6:0] v;
    bit acc_now;
    cur_rl = (segments_in == m_last_s) ? ((m_rl_last < RL_CAP) ? m_rl_last + 1 : RL_CAP) : 1;
    m_last_s = segments_in; m_rl_last = cur_rl;
    q_v.push_back(segments_in); q_rl.push_back(cur_rl);
    v = q_v.pop_front(); r = q_rl.pop_front();
    acc_now = (r == S + 1) && (v != m_acc);
    per = m_n - m_last_acc;
    if (per > (1 << CNT_W) - 1) per = (1 << CNT_W) - 1;
    d = seg_to_digit(v);
    m_nd = 0; m_inv = 0; m_seq = 0; m_te = 0;
    if (acc_now) begin m_acc = v; m_last_acc = m_n; end
    if (clear) begin
      m_run = 0; m_err = '0; m_pv = 0;
      if (acc_now) begin
        m_valid = (d >= 0);
        if (d >= 0) m_digit = 4'(d);
      end
    end else if (acc_now) begin
      if (v == 7'h00) begin
        m_valid = 0; m_run = 0;
      end else if (d < 0) begin
        m_inv = 1; m_valid = 0; m_run = 0;
        if (m_err != '1) m_err = m_err + 1'b1;
      end else begin
        if (m_run == 0) begin
          m_pv = 0; m_run = 1;
        end else begin
          m_seq = (d != (int'(m_digit) + 1) % 10);
          if (m_seq && m_err != '1) m_err = m_err + 1'b1;
          m_period = CNT_W'(per); m_pv = 1;
          dev = per - int'(expected_period);
          if (dev < 0) dev = -dev;
          m_te = TE_ON && (dev > TOL);
          m_run = 2;
        end
        m_digit = 4'(d); m_valid = 1; m_nd = 1;
      end
    end
    m_n++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  function automatic logic [63:0] dut_vec();
    return 64'({digit_out, digit_valid, new_digit, invalid_pattern, period_out,
                period_valid, seq_err, err_count, timing_err});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({m_digit, m_valid, m_nd, m_inv, m_period, m_pv, m_seq, m_err, m_te});
  endfunction

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) check("cycle", dut_vec(), model_vec());
  end

  // ---------------- stimulus helpers ----------------
  int               first_idx, nd_in;
  bit               got_inv;
  logic             s_seq, s_te, s_pv;
  logic [3:0]       s_digit;
  logic [CNT_W-1:0] s_period;
  logic [ERR_W-1:0] s_err;

  // Hold a pattern for n cycles, snapshotting outputs at any new_digit pulse.
  task automatic hold_watch(input logic [6:0] v, input int n);
    segments_in = v;
    first_idx = -1; nd_in = 0; got_inv = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (invalid_pattern) got_inv = 1;
      if (new_digit) begin
        if (first_idx < 0) first_idx = i;
        nd_in++;
        s_seq = seq_err; s_te = timing_err; s_pv = period_valid;
        s_digit = digit_out; s_period = period_out; s_err = err_count;
      end
    end
  endtask

  task automatic hold_rand(input logic [6:0] v, input int n, input int clr_at);
    segments_in = v;
    for (int i = 0; i < n; i++) begin
      clear = (i == clr_at);
      @(negedge clk);
    end
    clear = 0;
  endtask

  initial begin
    reset_n = 0; clear = 0; segments_in = 7'h3F;
    expected_period = CNT_W'(EXP_P);
    repeat (3) @(negedge clk);
    check("reset_state", dut_vec(), 64'd0);
    cmp_en = 1;

    // 1: held 0 after reset release
    reset_n = 1;
    hold_watch(7'h3F, 100);
    check("t1_latency", first_idx, S + 2);
    check("t1_digit", s_digit, 0);
    check("t1_seq", s_seq, 0);
    check("t1_pvalid", s_pv, 0);
    check("t1_valid", digit_valid, 1);
    check("t1_model_digit", m_digit, 0);

    // 2: 1..9,0 every 100 cycles
    for (int k = 1; k <= 10; k++) begin
      hold_watch(pat[k % 10], 100);
      check("t2_count", nd_in, 1);
      check("t2_digit", s_digit, k % 10);
      check("t2_seq", s_seq, 0);
      check("t2_period", s_period, 100);
      check("t2_pvalid", s_pv, 1);
    end
    check("t2_model_period", m_period, 100);
    check("t2_err", err_count, 0);

    // 3: short glitch is dropped
    hold_watch(7'h06, 2);
    check("t3_glitch_nd", nd_in, 0);
    hold_watch(7'h3F, 30);
    check("t3_after_nd", nd_in, 0);
    check("t3_err", err_count, 0);
    check("t3_digit", digit_out, 0);

    // 4: 3 then 5 is a sequence error, then 6 is fine
    clear = 1; @(negedge clk); clear = 0;
    hold_watch(pat[3], 50);
    check("t4_d3_seq", s_seq, 0);
    check("t4_d3_digit", s_digit, 3);
    hold_watch(pat[5], 50);
    check("t4_d5_seq", s_seq, 1);
    check("t4_d5_digit", s_digit, 5);
    check("t4_d5_err", s_err, 1);
    hold_watch(pat[6], 50);
    check("t4_d6_seq", s_seq, 0);
    check("t4_d6_err", s_err, 1);

    // 5: invalid pattern, then asynchronous reset mid-filter
    hold_watch(7'h55, 30);
    check("t5_inv", got_inv, 1);
    check("t5_nd", nd_in, 0);
    check("t5_valid", digit_valid, 0);
    check("t5_err", err_count, 2);
    segments_in = 7'h3F;
    repeat (3) @(negedge clk);
    #2 reset_n = 0;
    #1 check("t5_async_reset", dut_vec(), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    hold_watch(7'h3F, 103);
    check("t5_relatency", first_idx, S + 2);
    check("t5_once", nd_in, 1);
    check("t5_pvalid", s_pv, 0);

    // 6: period tolerance
    hold_watch(pat[1], 102);
    check("t6_p103", s_period, 103);
    check("t6_te103", s_te, TE_ON);
    hold_watch(pat[2], 60);
    check("t6_p102", s_period, 102);
    check("t6_te102", s_te, 0);
    check("t6_model_period", m_period, 102);

    // 7: randomized traffic
    for (int r = 0; r < 160; r++) begin
      int kind, len, clr_at;
      logic [6:0] v;
      kind = $urandom_range(0, 99);
      if (kind < 55)      v = pat[(int'(m_digit) + 1) % 10];
      else if (kind < 70) v = pat[$urandom_range(0, 9)];
      else if (kind < 78) v = 7'h00;
      else if (kind < 86) v = 7'($urandom_range(1, 127));
      else                v = pat[$urandom_range(0, 9)];
      if (kind >= 86) len = $urandom_range(1, S);
      else case ($urandom_range(0, 2))
        0:       len = $urandom_range(S + 1, 40);
        1:       len = $urandom_range(97, 104);
        default: len = $urandom_range(41, 96);
      endcase
      case ($urandom_range(0, 15))
        0:       clr_at = S + 2;
        1:       clr_at = $urandom_range(0, len - 1);
        default: clr_at = -1;
      endcase
      hold_rand(v, len, clr_at);
    end
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
